// File: rtl/ysyx_25040101_regfile_mp.sv
// Two-write-port register file with a per-register pending (busy) scoreboard.
// Port 1 (LSU) wins over port 0 (ALU) on a same-address collision.
// Optional same-cycle write-to-read forwarding: define YSYX_25040101_REGFILE_BYPASS_EN.
// AW defaults to clog2(NREG); it may be overridden wider (e.g. NREG=16 with AW=5),
// in which case addresses >= NREG are ignored on writes and read back as 0.
module ysyx_25040101_regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wen1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic [XLEN-1:0] reg_a0_o
);

  localparam int unsigned IW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt_c;
  logic            we0_c;
  logic            we1_c;
  logic            set_c;

  // Nonzero and inside the implemented register range.
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  // Committed write/issue qualifiers; nothing commits while reset is held.
  always_comb begin
    we1_c = rst_n && wen1 && valid_addr(waddr1);
    we0_c = rst_n && wen0 && valid_addr(waddr0) && !(we1_c && (waddr1 == waddr0));
    set_c = rst_n && iss_valid && valid_addr(iss_rd);
  end

  // Register storage; x0 is never written so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      if (we0_c) regs[IW'(waddr0)] <= wdata0;
      if (we1_c) regs[IW'(waddr1)] <= wdata1;
    end
  end

  // Scoreboard next state: writes clear, issue sets, set wins over clear.
  always_comb begin
    busy_nxt_c = busy;
    if (we0_c) busy_nxt_c[IW'(waddr0)] = 1'b0;
    if (we1_c) busy_nxt_c[IW'(waddr1)] = 1'b0;
    if (set_c) busy_nxt_c[IW'(iss_rd)] = 1'b1;
    busy_nxt_c[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt_c;
  end

  // Read port 1: stored value, optionally forwarded from a same-cycle write.
  always_comb begin
    rs1_data_o = '0;
    if (valid_addr(rs1_addr_i)) begin
      rs1_data_o = regs[IW'(rs1_addr_i)];
`ifdef YSYX_25040101_REGFILE_BYPASS_EN
      if (we0_c && (waddr0 == rs1_addr_i)) rs1_data_o = wdata0;
      if (we1_c && (waddr1 == rs1_addr_i)) rs1_data_o = wdata1;
`endif
    end
  end

  // Read port 2: same as port 1.
  always_comb begin
    rs2_data_o = '0;
    if (valid_addr(rs2_addr_i)) begin
      rs2_data_o = regs[IW'(rs2_addr_i)];
`ifdef YSYX_25040101_REGFILE_BYPASS_EN
      if (we0_c && (waddr0 == rs2_addr_i)) rs2_data_o = wdata0;
      if (we1_c && (waddr1 == rs2_addr_i)) rs2_data_o = wdata1;
`endif
    end
  end

  // Busy lookups come from registered scoreboard state only.
  always_comb begin
    rs1_busy_o = valid_addr(rs1_addr_i) ? busy[IW'(rs1_addr_i)] : 1'b0;
    rs2_busy_o = valid_addr(rs2_addr_i) ? busy[IW'(rs2_addr_i)] : 1'b0;
  end

  assign reg_a0_o = regs[IW'(10)];

endmodule

// File: tb/tb_ysyx_25040101_regfile_mp.sv
// Directed, table-driven bench for the two-write-port register file.
// A second instance (NREG=16, AW=5) covers out-of-range addresses.
module tb_ysyx_25040101_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
`ifdef YSYX_25040101_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic            wen0, wen1, iss_valid;
  logic [AW-1:0]   waddr0, waddr1, iss_rd, rs1_addr, rs2_addr;
  logic [XLEN-1:0] wdata0, wdata1, rs1_data, rs2_data, a0;
  logic            rs1_busy, rs2_busy;

  logic            s_wen0, s_wen1, s_iss_valid;
  logic [AW-1:0]   s_waddr0, s_waddr1, s_iss_rd, s_rs1_addr, s_rs2_addr;
  logic [XLEN-1:0] s_wdata0, s_wdata1, s_rs1_data, s_rs2_data, s_a0;
  logic            s_rs1_busy, s_rs2_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_25040101_regfile_mp #(.XLEN(XLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .reg_a0_o(a0)
  );

  ysyx_25040101_regfile_mp #(.XLEN(XLEN), .NREG(16), .AW(AW)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .wen0(s_wen0), .waddr0(s_waddr0), .wdata0(s_wdata0),
    .wen1(s_wen1), .waddr1(s_waddr1), .wdata1(s_wdata1),
    .rs1_addr_i(s_rs1_addr), .rs2_addr_i(s_rs2_addr),
    .rs1_data_o(s_rs1_data), .rs2_data_o(s_rs2_data),
    .iss_valid(s_iss_valid), .iss_rd(s_iss_rd),
    .rs1_busy_o(s_rs1_busy), .rs2_busy_o(s_rs2_busy),
    .reg_a0_o(s_a0)
  );

  typedef struct {
    logic        w0;
    logic [4:0]  wa0;
    logic [31:0] d0;
    logic        w1;
    logic [4:0]  wa1;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
    logic [31:0] ea0;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    iss_valid = 0; iss_rd = '0;
  endtask

  task automatic s_idle();
    s_wen0 = 0; s_waddr0 = '0; s_wdata0 = '0;
    s_wen1 = 0; s_waddr1 = '0; s_wdata1 = '0;
    s_iss_valid = 0; s_iss_rd = '0; s_rs1_addr = '0; s_rs2_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        w0 wa0 d0            w1 wa1 d1            iv ir  r1  r2  e1            e2            b1 b2 ea0
    vt[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0};
    vt[1]  = '{1, 3,  32'h11,       1, 3,  32'h22,       0, 0,  3,  5,  32'h22,       32'hDEADBEEF, 0, 0, 32'h0};
    vt[2]  = '{1, 0,  32'hFFFFFFFF, 1, 0,  32'hFFFFFFFF, 0, 0,  0,  3,  32'h0,        32'h22,       0, 0, 32'h0};
    vt[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  7,  0,  32'h0,        32'h0,        1, 0, 32'h0};
    vt[4]  = '{1, 7,  32'h5,        0, 0,  32'h0,        0, 0,  7,  0,  32'h5,        32'h0,        0, 0, 32'h0};
    vt[5]  = '{0, 0,  32'h0,        1, 7,  32'h6,        1, 7,  7,  7,  32'h6,        32'h6,        1, 1, 32'h0};
    vt[6]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 0,  0,  7,  32'h0,        32'h6,        0, 1, 32'h0};
    vt[7]  = '{1, 10, 32'h2A,       1, 12, 32'h1234,     0, 0,  10, 12, 32'h2A,       32'h1234,     0, 0, 32'h2A};
    vt[8]  = '{1, 7,  32'h9,        0, 0,  32'h0,        1, 12, 7,  12, 32'h9,        32'h1234,     0, 1, 32'h2A};
    vt[9]  = '{1, 31, 32'hFFFF0000, 1, 1,  32'h1,        0, 0,  31, 1,  32'hFFFF0000, 32'h1,        0, 0, 32'h2A};
    vt[10] = '{1, 1,  32'h2,        0, 0,  32'h0,        1, 1,  1,  12, 32'h2,        32'h1234,     1, 1, 32'h2A};

    // Reset held with active writes/issues: everything reads 0.
    s_idle();
    rst_n = 0;
    wen0 = 1; waddr0 = 5; wdata0 = 32'h1;
    wen1 = 1; waddr1 = 10; wdata1 = 32'h55;
    iss_valid = 1; iss_rd = 7;
    rs1_addr = 5; rs2_addr = 7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rs1_data", rs1_data, 32'h0);
    check("rst_rs2_data", rs2_data, 32'h0);
    check("rst_rs2_busy", 32'(rs2_busy), 32'h0);
    check("rst_a0", a0, 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1;

    // Table: drive at negedge, commit on posedge, then check stored state.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      wen0 = vt[i].w0; waddr0 = vt[i].wa0; wdata0 = vt[i].d0;
      wen1 = vt[i].w1; waddr1 = vt[i].wa1; wdata1 = vt[i].d1;
      iss_valid = vt[i].iv; iss_rd = vt[i].ir;
      rs1_addr = vt[i].r1; rs2_addr = vt[i].r2;
      @(posedge clk);
      #1;
      idle();
      #1;
      check($sformatf("v%0d_rs1_data", i), rs1_data, vt[i].e1);
      check($sformatf("v%0d_rs2_data", i), rs2_data, vt[i].e2);
      check($sformatf("v%0d_rs1_busy", i), 32'(rs1_busy), 32'(vt[i].b1));
      check($sformatf("v%0d_rs2_busy", i), 32'(rs2_busy), 32'(vt[i].b2));
      check($sformatf("v%0d_a0", i), a0, vt[i].ea0);
    end

    // Same-cycle read of a write in flight.
    @(negedge clk);
    wen0 = 1; waddr0 = 9; wdata0 = 32'hA5; rs2_addr = 9;
    #1;
    check("byp_pre_edge", rs2_data, BYP ? 32'hA5 : 32'h0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("byp_post_edge", rs2_data, 32'hA5);

    // Both ports in flight to the same register: port 1 data visible.
    @(negedge clk);
    wen0 = 1; waddr0 = 9; wdata0 = 32'h1;
    wen1 = 1; waddr1 = 9; wdata1 = 32'h2;
    rs1_addr = 9;
    #1;
    check("byp_prio_pre_edge", rs1_data, BYP ? 32'h2 : 32'hA5);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("byp_prio_post_edge", rs1_data, 32'h2);

    // Asynchronous reset between edges while x1/x12 are busy.
    @(negedge clk);
    rs1_addr = 1; rs2_addr = 12;
    wen0 = 1; waddr0 = 5; wdata0 = 32'h77;
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_a0", a0, 32'h0);
    check("mid_rst_rs1_busy", 32'(rs1_busy), 32'h0);
    check("mid_rst_rs2_busy", 32'(rs2_busy), 32'h0);
    check("mid_rst_rs2_data", rs2_data, 32'h0);
    @(posedge clk);
    #1;
    rs1_addr = 5;
    #1;
    check("mid_rst_no_write", rs1_data, 32'h0);

    // First edge after release performs a normal write.
    @(negedge clk);
    rst_n = 1;
    wen0 = 1; waddr0 = 6; wdata0 = 32'h66;
    rs1_addr = 6;
    @(posedge clk);
    #1;
    idle();
    #1;
    check("post_rst_write", rs1_data, 32'h66);

    // 16-entry instance: an address with bit 4 set must not alias x4.
    @(negedge clk);
    s_wen0 = 1; s_waddr0 = 5'd4; s_wdata0 = 32'h44;
    @(posedge clk);
    #1;
    s_idle();
    @(negedge clk);
    s_wen0 = 1; s_waddr0 = 5'b10100; s_wdata0 = 32'hBAD;
    s_wen1 = 1; s_waddr1 = 5'b10100; s_wdata1 = 32'hBAD2;
    s_iss_valid = 1; s_iss_rd = 5'b10100;
    s_rs1_addr = 5'd4; s_rs2_addr = 5'b10100;
    @(posedge clk);
    #1;
    s_wen0 = 0; s_wen1 = 0; s_iss_valid = 0;
    #1;
    check("e_x4_kept", s_rs1_data, 32'h44);
    check("e_oor_read", s_rs2_data, 32'h0);
    check("e_oor_busy", 32'(s_rs2_busy), 32'h0);
    check("e_x4_busy", 32'(s_rs1_busy), 32'h0);
    check("e_a0", s_a0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
